// File: rtl/dec_pkg.sv
// Shared types and helpers for the saturating decrementer stream.
// Holds the MIN-value helper, the default beat layout and the occupancy states.
package dec_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  // Most negative two's complement value of a given width, right-aligned in 64 bits
  function automatic logic [63:0] sat_min(input int width);
    logic [63:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] data;
    logic                             sat;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } occ_state_e;

endpackage

// File: rtl/decrementer_stream_if.sv
// Valid/ready bundle for the decrementer: upstream operand side and downstream result side.
// The slave modport is the decrementer itself; master is whoever drives and drains it.
interface decrementer_stream_if #(
  parameter int DATA_WIDTH = 8
);

  logic signed [DATA_WIDTH-1:0] data_i;
  logic                         valid_i;
  logic                         ready_o;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         sat_o;
  logic                         valid_o;
  logic                         ready_i;

  modport slave (
    input  data_i,
    input  valid_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output sat_o,
    output valid_o
  );

  modport master (
    output data_i,
    output valid_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  sat_o,
    input  valid_o
  );

endinterface

// File: rtl/dec_core.sv
// Combinational saturating signed decrement: MIN stays MIN and flags sat,
// every other value (including 0 -> -1) is a plain two's complement minus one.
module dec_core
  import dec_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         sat_o
);

  localparam logic [63:0]                  MIN_WIDE = sat_min(DATA_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = MIN_WIDE[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] ONE_VAL  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    sat_o  = (data_i == MIN_VAL);
    data_o = sat_o ? MIN_VAL : (data_i - ONE_VAL);
  end

endmodule

// File: rtl/decrementer_stream.sv
// Streaming saturating decrementer: one-cycle latency, 2-entry skid buffer (main M + skid S).
// Optional saturation event counter enabled by defining DEC_SAT_CNT_EN.
module decrementer_stream
  import dec_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef DEC_SAT_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef DEC_SAT_CNT_EN
  input  logic                 sat_cnt_clr_i,
  output logic [CNT_WIDTH-1:0] sat_cnt_o,
`endif
  decrementer_stream_if.slave  bus
);

  logic signed [DATA_WIDTH-1:0] w_decData;
  logic                         w_decSat;
  logic signed [DATA_WIDTH-1:0] r_mData;
  logic                         r_mSat;
  logic signed [DATA_WIDTH-1:0] r_sData;
  logic                         r_sSat;
  occ_state_e                   r_state;
  occ_state_e                   w_nextState;
  logic                         r_valid;
  logic                         r_ready;
  logic                         w_inXfer;
  logic                         w_outXfer;
  logic                         w_loadMIn;
  logic                         w_loadMSkid;
  logic                         w_loadS;

  dec_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .data_i(bus.data_i),
    .data_o(w_decData),
    .sat_o (w_decSat)
  );

  assign w_inXfer  = bus.valid_i && r_ready;
  assign w_outXfer = r_valid && bus.ready_i;

  // Occupancy FSM: decides where an accepted beat lands and when S moves up into M
  always_comb begin
    w_nextState = r_state;
    w_loadMIn   = 1'b0;
    w_loadMSkid = 1'b0;
    w_loadS     = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_inXfer) begin
          w_nextState = ST_ONE;
          w_loadMIn   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_inXfer && w_outXfer) begin
          w_loadMIn = 1'b1;
        end else if (w_inXfer) begin
          w_nextState = ST_FULL;
          w_loadS     = 1'b1;
        end else if (w_outXfer) begin
          w_nextState = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_outXfer) begin
          w_nextState = ST_ONE;
          w_loadMSkid = 1'b1;
        end
      end
      default: w_nextState = ST_EMPTY;
    endcase
  end

  // valid/ready are flopped from the next state so neither has a path from ready_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_valid <= (w_nextState != ST_EMPTY);
      r_ready <= (w_nextState != ST_FULL);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mData <= '0;
      r_mSat  <= 1'b0;
      r_sData <= '0;
      r_sSat  <= 1'b0;
    end else begin
      if (w_loadMIn) begin
        r_mData <= w_decData;
        r_mSat  <= w_decSat;
      end else if (w_loadMSkid) begin
        r_mData <= r_sData;
        r_mSat  <= r_sSat;
      end
      if (w_loadS) begin
        r_sData <= w_decData;
        r_sSat  <= w_decSat;
      end
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_mData;
  assign bus.sat_o   = r_mSat;

`ifdef DEC_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] r_satCnt;

  // Counts clamped beats as they leave; sticks at all-ones, clear beats increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_satCnt <= '0;
    end else if (sat_cnt_clr_i) begin
      r_satCnt <= '0;
    end else if (w_outXfer && r_mSat && (r_satCnt != '1)) begin
      r_satCnt <= r_satCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign sat_cnt_o = r_satCnt;
`endif

endmodule

// File: tb/tb_decrementer_stream.sv
// Directed and randomised bench for decrementer_stream (DATA_WIDTH=8).
// With DEC_SAT_CNT_EN defined the counter is built 4 bits wide so saturation is reachable quickly.
module tb_decrementer_stream;
  import dec_pkg::*;

  logic clk_i;
  logic rst_i;
  int   vectors;
  int   errors;

  decrementer_stream_if #(.DATA_WIDTH(8)) bus ();

`ifdef DEC_SAT_CNT_EN
  logic       sat_cnt_clr_i;
  logic [3:0] sat_cnt_o;
`endif

  decrementer_stream #(
    .DATA_WIDTH(8)
`ifdef DEC_SAT_CNT_EN
    ,
    .CNT_WIDTH (4)
`endif
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
`ifdef DEC_SAT_CNT_EN
    .sat_cnt_clr_i(sat_cnt_clr_i),
    .sat_cnt_o    (sat_cnt_o),
`endif
    .bus          (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic beat_t decModel(input logic [7:0] x);
    beat_t b;
    if (x == 8'h80) begin
      b.data = 8'sh80;
      b.sat  = 1'b1;
    end else begin
      b.data = x - 8'd1;
      b.sat  = 1'b0;
    end
    return b;
  endfunction

  // Advance one clock; inputs and checks happen 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
`ifdef DEC_SAT_CNT_EN
    sat_cnt_clr_i = 1'b0;
`endif
    step();
    step();
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_handshake: valid_o=%b ready_o=%b, expected valid_o=0 ready_o=1", bus.valid_o, bus.ready_o);
    end
    vectors++;
    if (bus.data_o !== 8'h00 || bus.sat_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: data_o=%h sat_o=%b, expected 00/0", bus.data_o, bus.sat_o);
    end
`ifdef DEC_SAT_CNT_EN
    vectors++;
    if (sat_cnt_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: sat_cnt_o=%h, expected 0", sat_cnt_o);
    end
`endif
    #2;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] inV  [3];
    logic [7:0] expV [3];
    inV  = '{8'd5, 8'd0, 8'd127};
    expV = '{8'd4, 8'hFF, 8'd126};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_i  = inV[i];
      bus.valid_i = 1'b1;
      step();
      vectors++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== expV[i] || bus.sat_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_%0d: valid=%b data=%h sat=%b, expected 1/%h/0", i, bus.valid_o, bus.data_o, bus.sat_o, expV[i]);
      end
    end
    bus.valid_i = 1'b0;
    step();
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_drain: valid=%b ready=%b, expected 0/1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] inV  [2];
    logic [7:0] expV [2];
    logic       expS [2];
    inV  = '{8'h80, 8'h81};
    expV = '{8'h80, 8'h80};
    expS = '{1'b1, 1'b0};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.data_i  = inV[i];
      bus.valid_i = 1'b1;
      step();
      vectors++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== expV[i] || bus.sat_o !== expS[i]) begin
        errors++;
        $display("[TB] FAIL saturate_%0d: valid=%b data=%h sat=%b, expected 1/%h/%b", i, bus.valid_o, bus.data_o, bus.sat_o, expV[i], expS[i]);
      end
    end
    bus.valid_i = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'd10;
    step();
    vectors++;
    if (bus.data_o !== 8'd9 || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_first: data=%0d valid=%b ready=%b, expected 9/1/1", bus.data_o, bus.valid_o, bus.ready_o);
    end
    bus.data_i = 8'd20;
    step();
    vectors++;
    if (bus.data_o !== 8'd9 || bus.ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_full: data=%0d ready=%b, expected 9/0", bus.data_o, bus.ready_o);
    end
    bus.data_i = 8'd30;
    step();
    vectors++;
    if (bus.data_o !== 8'd9 || bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold: data=%0d ready=%b valid=%b, expected 9/0/1", bus.data_o, bus.ready_o, bus.valid_o);
    end
    bus.ready_i = 1'b1;
    step();
    vectors++;
    if (bus.data_o !== 8'd19 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_skid: data=%0d ready=%b, expected 19/1", bus.data_o, bus.ready_o);
    end
    step();
    vectors++;
    if (bus.data_o !== 8'd29 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_third: data=%0d valid=%b, expected 29/1", bus.data_o, bus.valid_o);
    end
    bus.valid_i = 1'b0;
    step();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: valid=%b, expected 0", bus.valid_o);
    end
  endtask

  task automatic test_random();
    beat_t      q[$];
    beat_t      head;
    int         accepted;
    int         cyc;
    logic       holdValid;
    logic [7:0] holdData;
    logic       holdSat;
    logic       inX;
    logic       outX;
    logic [7:0] d;
    accepted  = 0;
    cyc       = 0;
    holdValid = 1'b0;
    holdData  = '0;
    holdSat   = 1'b0;
    while ((accepted < 10000 || q.size() > 0) && cyc < 40000) begin
      vectors++;
      if (bus.valid_o !== (q.size() > 0) || bus.ready_o !== (q.size() < 2)) begin
        errors++;
        $display("[TB] FAIL rand_hs cyc %0d: valid=%b ready=%b, expected %b/%b", cyc, bus.valid_o, bus.ready_o, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        head = q[0];
        vectors++;
        if (bus.data_o !== head.data || bus.sat_o !== head.sat) begin
          errors++;
          $display("[TB] FAIL rand_data cyc %0d: data=%h sat=%b, expected %h/%b", cyc, bus.data_o, bus.sat_o, head.data, head.sat);
        end
      end
      if (holdValid) begin
        vectors++;
        if (bus.data_o !== holdData || bus.sat_o !== holdSat || bus.valid_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rand_stable cyc %0d: data=%h sat=%b valid=%b, expected %h/%b/1", cyc, bus.data_o, bus.sat_o, bus.valid_o, holdData, holdSat);
        end
      end
      case ($urandom_range(0, 7))
        0:       d = 8'h80;
        1:       d = 8'h00;
        2:       d = 8'h81;
        default: d = 8'($urandom_range(0, 255));
      endcase
      bus.data_i  = d;
      bus.valid_i = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      bus.ready_i = (accepted >= 10000) || ($urandom_range(0, 9) < 7);
      inX  = bus.valid_i && (q.size() < 2);
      outX = (q.size() > 0) && bus.ready_i;
      holdValid = (q.size() > 0) && !bus.ready_i;
      holdData  = bus.data_o;
      holdSat   = bus.sat_o;
      if (outX) void'(q.pop_front());
      if (inX) begin
        q.push_back(decModel(d));
        accepted++;
      end
      step();
      cyc++;
    end
    vectors++;
    if (accepted < 10000 || q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_budget: accepted=%0d pending=%0d, expected 10000/0", accepted, q.size());
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'd40;
    step();
    bus.data_i = 8'd41;
    step();
    #2;
    rst_i = 1'b1;
    #1;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== 8'h00 || bus.sat_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_rst: valid=%b ready=%b data=%h sat=%b, expected 0/1/00/0", bus.valid_o, bus.ready_o, bus.data_o, bus.sat_o);
    end
    bus.valid_i = 1'b0;
    step();
    step();
    #2;
    rst_i       = 1'b0;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'd50;
    step();
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'd49 || bus.sat_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_after: valid=%b data=%0d sat=%b, expected 1/49/0", bus.valid_o, bus.data_o, bus.sat_o);
    end
    bus.valid_i = 1'b0;
    step();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_drain: valid=%b, expected 0 (old beats must be dropped)", bus.valid_o);
    end
  endtask

`ifdef DEC_SAT_CNT_EN
  task automatic test_sat_cnt();
    vectors++;
    if (sat_cnt_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL cnt_start: sat_cnt_o=%h, expected 0", sat_cnt_o);
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h80;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (sat_cnt_o !== 4'h3) begin
      errors++;
      $display("[TB] FAIL cnt_three: sat_cnt_o=%h, expected 3", sat_cnt_o);
    end
    bus.valid_i   = 1'b0;
    sat_cnt_clr_i = 1'b1;
    step();
    sat_cnt_clr_i = 1'b0;
    vectors++;
    if (sat_cnt_o !== 4'h0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cnt_clear: sat_cnt_o=%h valid=%b, expected 0/0", sat_cnt_o, bus.valid_o);
    end
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h81;
    step();
    bus.valid_i = 1'b0;
    step();
    vectors++;
    if (sat_cnt_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL cnt_nonsat: sat_cnt_o=%h, expected 0", sat_cnt_o);
    end
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h80;
    for (int i = 0; i < 20; i++) step();
    bus.valid_i = 1'b0;
    step();
    step();
    vectors++;
    if (sat_cnt_o !== 4'hF) begin
      errors++;
      $display("[TB] FAIL cnt_saturate: sat_cnt_o=%h, expected F", sat_cnt_o);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_random();
    test_async_reset();
`ifdef DEC_SAT_CNT_EN
    test_sat_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
